axil_regbank: RTL and testbench
===============================

Name: axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 4 x 32-bit slave register set in the videoprocessor IP.
- Generalised in register count and data width.
- Adds per-byte write strobes, read-only hardware-status registers, out-of-range SLVERR decode and per-register write-commit pulses.
- Sits between the PS AXI interconnect and video-pipeline control/status logic.

Parameters:
- NUM_REGS, 4: number of registers; range 1..256.
- DATA_W, 32: register/bus width; 32 or 64.
- ADDR_W, 8: AXI address width; must satisfy 2^(ADDR_W-log2(DATA_W/8)) > NUM_REGS.
- RO_MASK, 0: NUM_REGS-bit mask; bit i=1 makes reg i read-only, sourced from hw_status.
- RESET_VAL, 0: DATA_W reset value applied to every RW register.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  DATA_W  write data.
- s_axi_wstrb  in  DATA_W/8  byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  ADDR_W  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  DATA_W  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- reg_out  out  NUM_REGS*DATA_W  flattened register contents; reg i at [i*DATA_W +: DATA_W].
- hw_status  in  NUM_REGS*DATA_W  read value for RO registers; unused slices ignored.
- wr_pulse  out  NUM_REGS  one-cycle strobe when reg i is written.

Behaviour:
- Reset (ARESET=1 at ACLK edge):
  - RW regs <= RESET_VAL.
  - All valid outputs, all ready outputs and wr_pulse = 0; bresp/rresp = 0; rdata = 0.
  - Readies rise the first cycle after ARESET deasserts.
  - Reset mid-transaction discards captured AW/W/AR; no B or R is issued for them.
- Index decode: idx = addr[ADDR_W-1:log2(DATA_W/8)]; low byte-offset bits are ignored.
- Write channel states: IDLE, HAVE_AW, HAVE_W, COMMIT, RESP.
  - awready=1 only when no AW is captured and state != RESP; wready likewise for W.
  - AW and W may arrive in either order or in the same cycle.
  - Once both are captured, COMMIT takes one cycle:
    - If idx < NUM_REGS and RO_MASK[idx]=0: bytes with wstrb=1 are updated, wr_pulse[idx]=1 for that cycle.
    - Then bvalid=1 the next cycle.
  - bvalid holds with stable bresp until bready; return to IDLE.
  - One outstanding write maximum.
- bresp:
  - OKAY (2'b00) for in-range indexes, including RO registers (write silently ignored, no wr_pulse).
  - SLVERR (2'b10) for idx >= NUM_REGS; no state change.
- Read channel:
  - arready = !rvalid.
  - On AR handshake, rdata/rresp are registered and rvalid=1 the next cycle.
  - Data source: reg value for RW, hw_status slice for RO, 0 with SLVERR if out of range.
  - rdata/rresp stay stable until rready; arready returns to 1 the cycle after the R handshake.
- Read and write channels are independent and run concurrently.
  - If the AR handshake and a COMMIT to the same reg share a cycle, the read returns the pre-write value.
- Latency: write AW+W → B is 2 cycles min; AR → R is 1 cycle.

Optional Feature:
- Macro AXIL_REGBANK_IRQ_EN.
- When defined:
  - Adds input irq_event[DATA_W-1:0] and output irq.
  - Adds a W1C sticky status register at idx = NUM_REGS (no longer SLVERR).
  - Each bit sets on irq_event high; written-1 bits with wstrb clear. Set wins over a simultaneous clear.
  - irq is registered: irq = |status, 1 cycle after the status change.
  - Reset value 0.
- When undefined: no extra ports; idx NUM_REGS returns SLVERR.

Decomposition:
- Package axil_regbank_pkg:
  - resp_t with RESP_OKAY/RESP_SLVERR.
  - wr_state_t enum (IDLE, HAVE_AW, HAVE_W, COMMIT, RESP).
  - Function for the byte-offset width.
- Sub-module axil_regbank_wr_ctrl: AW/W capture FSM and B generation.
- Storage, read path and IRQ register stay in the top level.

Test Plan:
- Reset defaults, RESET_VAL=0: release ARESET → read idx 0..3 returns 0 OKAY; readies high 1 cycle after release.
- Strobes and pulse:
  - Write 0x11223344 to 0x04 with wstrb=4'b0101 over 0x00000000 → reads 0x00220044.
  - wr_pulse[1] is high exactly one cycle.
- AW/W ordering: W issued 3 cycles before AW → single B OKAY, data committed; bvalid held with bready low for 5 cycles stays stable.
- RO and range, RO_MASK=4'b1000, hw_status[3]=0xCAFEF00D:
  - Write 0x0C → OKAY, no pulse.
  - Read 0x0C → 0xCAFEF00D.
  - Read 0x10 → SLVERR, data 0.
- Collision: reg2=0x5; AR to 0x08 in same cycle as COMMIT of 0x9 → R returns 0x5; subsequent read returns 0x9.
- IRQ, with AXIL_REGBANK_IRQ_EN:
  - Pulse irq_event[0] → irq=1 next cycle.
  - Write 0x1 to 0x10 with irq_event[0] high in the same cycle → bit stays set.
  - Repeat with irq_event low → irq falls.

Source files
------------

// File: rtl/axil_regbank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank and its write controller.
package axil_regbank_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    StIdle,
    StHaveAw,
    StHaveW,
    StCommit,
    StResp
  } wr_state_t;

  // Number of address LSBs that select a byte within one bus word.
  function automatic int unsigned byte_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axil_regbank_wr_ctrl.sv
// AXI4-Lite write channel: captures AW and W in any order, commits for one cycle, then
// holds B until accepted. One outstanding write at a time.
module axil_regbank_wr_ctrl
  import axil_regbank_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  output logic                commit_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [DATA_W/8-1:0] strb_o,
  input  logic                commit_err_i
);

  wr_state_t           state_q, state_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  resp_t               bresp_q, bresp_d;

  always_comb begin
    state_d   = state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    awready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    commit_o  = 1'b0;
    case (state_q)
      StIdle: begin
        awready_o = en_i;
        wready_o  = en_i;
        if (en_i && awvalid_i) awaddr_d = awaddr_i;
        if (en_i && wvalid_i) begin
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
        end
        if (en_i && awvalid_i && wvalid_i) state_d = StCommit;
        else if (en_i && awvalid_i)        state_d = StHaveAw;
        else if (en_i && wvalid_i)         state_d = StHaveW;
      end
      StHaveAw: begin
        wready_o = en_i;
        if (en_i && wvalid_i) begin
          wdata_d = wdata_i;
          wstrb_d = wstrb_i;
          state_d = StCommit;
        end
      end
      StHaveW: begin
        awready_o = en_i;
        if (en_i && awvalid_i) begin
          awaddr_d = awaddr_i;
          state_d  = StCommit;
        end
      end
      StCommit: begin
        commit_o = 1'b1;
        bresp_d  = commit_err_i ? RESP_SLVERR : RESP_OKAY;
        state_d  = StResp;
      end
      StResp: begin
        bvalid_o = 1'b1;
        if (bready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
    end
  end

  assign bresp_o = bresp_q;
  assign addr_o  = awaddr_q;
  assign data_o  = wdata_q;
  assign strb_o  = wstrb_q;

endmodule

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite register bank with RW/RO registers, byte strobes and write pulses.
// Define AXIL_REGBANK_IRQ_EN to add a W1C sticky interrupt status register at index NUM_REGS.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int unsigned         NUM_REGS  = 4,
  parameter int unsigned         DATA_W    = 32,
  parameter int unsigned         ADDR_W    = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [DATA_W-1:0]          s_axi_wdata,
  input  logic [DATA_W/8-1:0]        s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [DATA_W-1:0]          s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] hw_status,
  output logic [NUM_REGS-1:0]        wr_pulse
`ifdef AXIL_REGBANK_IRQ_EN
  ,
  input  logic [DATA_W-1:0]          irq_event,
  output logic                       irq
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = byte_off_w(DATA_W);
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Readies stay low until one clock edge has seen reset released.
  logic rdy_q;

  logic              wr_commit, wr_err, wr_in_range, wr_ro, wr_irq_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, strb_mask;
  logic [STRB_W-1:0] wr_strb;
  logic [IDX_W-1:0]  wr_idx, ar_idx;

  logic              ar_hs, rd_hit;
  logic [DATA_W-1:0] rd_val;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_t             rresp_q, rresp_d;

`ifdef AXIL_REGBANK_IRQ_EN
  logic [DATA_W-1:0] irq_status_q, irq_status_d;
  logic              irq_q;
`endif

  axil_regbank_wr_ctrl #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_wr_ctrl (
    .clk_i       (ACLK),
    .rst_i       (ARESET),
    .en_i        (rdy_q),
    .awaddr_i    (s_axi_awaddr),
    .awvalid_i   (s_axi_awvalid),
    .awready_o   (s_axi_awready),
    .wdata_i     (s_axi_wdata),
    .wstrb_i     (s_axi_wstrb),
    .wvalid_i    (s_axi_wvalid),
    .wready_o    (s_axi_wready),
    .bresp_o     (s_axi_bresp),
    .bvalid_o    (s_axi_bvalid),
    .bready_i    (s_axi_bready),
    .commit_o    (wr_commit),
    .addr_o      (wr_addr),
    .data_o      (wr_data),
    .strb_o      (wr_strb),
    .commit_err_i(wr_err)
  );

  assign wr_idx = wr_addr[ADDR_W-1:OFF_W];
  assign ar_idx = s_axi_araddr[ADDR_W-1:OFF_W];

  logic unused_lsb;
  assign unused_lsb = ^{wr_addr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

  always_comb begin
    wr_in_range = 1'b0;
    wr_ro       = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) begin
        wr_in_range = 1'b1;
        wr_ro       = RO_MASK[i];
      end
    end
`ifdef AXIL_REGBANK_IRQ_EN
    wr_irq_sel = (wr_idx == IDX_W'(NUM_REGS));
`else
    wr_irq_sel = 1'b0;
`endif
    wr_err = !(wr_in_range || wr_irq_sel);
    strb_mask = '0;
    for (int b = 0; b < STRB_W; b++) strb_mask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  always_comb begin
    regs_d   = regs_q;
    wr_pulse = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_commit && !wr_ro && wr_idx == IDX_W'(i)) begin
        wr_pulse[i] = 1'b1;
        regs_d[i]   = (regs_q[i] & ~strb_mask) | (wr_data & strb_mask);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
      rdy_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      rdy_q  <= 1'b1;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_W +: DATA_W] = regs_q[i];
  end

  // Read path samples regs_q before a same-cycle commit lands, so it returns the old value.
  assign s_axi_arready = rdy_q && !rvalid_q;
  assign ar_hs         = s_axi_arvalid && s_axi_arready;

  always_comb begin
    rd_hit = 1'b0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_hit = 1'b1;
        rd_val = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : regs_q[i];
      end
    end
`ifdef AXIL_REGBANK_IRQ_EN
    if (ar_idx == IDX_W'(NUM_REGS)) begin
      rd_hit = 1'b1;
      rd_val = irq_status_q;
    end
`endif
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;

`ifdef AXIL_REGBANK_IRQ_EN
  // Set has priority: an event arriving with a W1C write keeps its bit.
  always_comb begin
    irq_status_d = (irq_status_q & ~((wr_commit && wr_irq_sel) ? (wr_data & strb_mask) : '0))
                 | irq_event;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      irq_status_q <= irq_status_d;
      irq_q        <= |irq_status_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_axil_regbank.sv
// Scoreboard bench for axil_regbank: drivers push expected B/R/pulse responses, a negedge
// monitor pops and compares them. Covers the IRQ register when AXIL_REGBANK_IRQ_EN is defined.
module tb_axil_regbank;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 8;
  localparam logic [3:0]  RO_MASK  = 4'b1000;
  localparam logic [31:0] HW3      = 32'hCAFEF00D;

  logic         ACLK, ARESET;
  logic [7:0]   s_axi_awaddr, s_axi_araddr;
  logic         s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0]  s_axi_wdata, s_axi_rdata;
  logic [3:0]   s_axi_wstrb;
  logic [1:0]   s_axi_bresp, s_axi_rresp;
  logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic         s_axi_rvalid, s_axi_rready;
  logic [127:0] reg_out, hw_status;
  logic [3:0]   wr_pulse;
`ifdef AXIL_REGBANK_IRQ_EN
  logic [31:0]  irq_event;
  logic         irq;
  logic [31:0]  model_irq;
`endif

  axil_regbank #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .RO_MASK  (RO_MASK),
    .RESET_VAL(32'h0)
  ) dut (
    .ACLK         (ACLK),
    .ARESET       (ARESET),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .reg_out      (reg_out),
    .hw_status    (hw_status),
    .wr_pulse     (wr_pulse)
`ifdef AXIL_REGBANK_IRQ_EN
    ,
    .irq_event    (irq_event),
    .irq          (irq)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];
  logic [3:0]  exp_p_q[$];
  logic [31:0] model[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] exp_read(input logic [7:0] a);
    int idx = int'(a >> 2);
    if (idx < 4) return {2'b00, RO_MASK[idx] ? hw_status[idx*32 +: 32] : model[idx]};
`ifdef AXIL_REGBANK_IRQ_EN
    if (idx == 4) return {2'b00, model_irq};
`endif
    return {2'b10, 32'h0};
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a >> 2);
    logic [31:0] m;
    logic [3:0] p;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    if (idx < 4) begin
      exp_b_q.push_back(2'b00);
      if (!RO_MASK[idx]) begin
        model[idx] = (model[idx] & ~m) | (d & m);
        p = '0;
        p[idx] = 1'b1;
        exp_p_q.push_back(p);
      end
`ifdef AXIL_REGBANK_IRQ_EN
    end else if (idx == 4) begin
      exp_b_q.push_back(2'b00);
      model_irq = model_irq & ~(d & m);
`endif
    end else begin
      exp_b_q.push_back(2'b10);
    end
  endtask

  task automatic drive_aw(input logic [7:0] a, input int dly);
    bit hs = 1'b0;
    repeat (dly) begin @(posedge ACLK); #1; end
    s_axi_awaddr  = a;
    s_axi_awvalid = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge ACLK); hs = s_axi_awready;
      @(posedge ACLK); #1;
    end
    s_axi_awvalid = 1'b0;
    check("aw_handshake", 64'(hs), 64'd1);
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit hs = 1'b0;
    repeat (dly) begin @(posedge ACLK); #1; end
    s_axi_wdata  = d;
    s_axi_wstrb  = s;
    s_axi_wvalid = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge ACLK); hs = s_axi_wready;
      @(posedge ACLK); #1;
    end
    s_axi_wvalid = 1'b0;
    check("w_handshake", 64'(hs), 64'd1);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit hs = 1'b0;
    model_write(a, d, s);
    fork
      drive_aw(a, aw_dly);
      drive_w(d, s, w_dly);
    join
    repeat (b_dly) begin @(posedge ACLK); #1; end
    s_axi_bready = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge ACLK); hs = s_axi_bvalid;
      @(posedge ACLK); #1;
    end
    s_axi_bready = 1'b0;
    check("b_handshake", 64'(hs), 64'd1);
  endtask

  task automatic do_read(input logic [7:0] a, input int r_dly);
    bit hs = 1'b0;
    exp_r_q.push_back(exp_read(a));
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge ACLK); hs = s_axi_arready;
      @(posedge ACLK); #1;
    end
    s_axi_arvalid = 1'b0;
    check("ar_handshake", 64'(hs), 64'd1);
    hs = 1'b0;
    repeat (r_dly) begin @(posedge ACLK); #1; end
    s_axi_rready = 1'b1;
    for (int k = 0; k < 40 && !hs; k++) begin
      @(negedge ACLK); hs = s_axi_rvalid;
      @(posedge ACLK); #1;
    end
    s_axi_rready = 1'b0;
    check("r_handshake", 64'(hs), 64'd1);
  endtask

  // Monitor: responses, one-cycle pulses, and stability of B/R while stalled.
  bit          b_pend = 1'b0, r_pend = 1'b0;
  logic [1:0]  b_prev;
  logic [33:0] r_prev;
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (b_pend) check("b_stable", {s_axi_bvalid, s_axi_bresp}, {1'b1, b_prev});
      if (r_pend) check("r_stable", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, r_prev});
      if (|wr_pulse) begin
        if (exp_p_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_pulse_unexpected: got %0h required 0", wr_pulse);
        end else check("wr_pulse", wr_pulse, exp_p_q.pop_front());
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b_unexpected: got bresp %0h required no response", s_axi_bresp);
        end else check("bresp", s_axi_bresp, exp_b_q.pop_front());
        check("pulse_before_b", exp_p_q.size(), 0);
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL r_unexpected: got %0h required no response", s_axi_rdata);
        end else check("rresp_rdata", {s_axi_rresp, s_axi_rdata}, exp_r_q.pop_front());
      end
    end
    b_pend = s_axi_bvalid && !s_axi_bready && !ARESET;
    b_prev = s_axi_bresp;
    r_pend = s_axi_rvalid && !s_axi_rready && !ARESET;
    r_prev = {s_axi_rresp, s_axi_rdata};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  logic [7:0] ra;
  logic [2:0] ridx;

  initial begin
    ARESET = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    hw_status = {HW3, 32'h0BAD0002, 32'h0BAD0001, 32'h0BAD0000};
    for (int i = 0; i < 4; i++) model[i] = '0;
`ifdef AXIL_REGBANK_IRQ_EN
    irq_event = '0;
    model_irq = '0;
`endif
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("reset_ctrl", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                         s_axi_rvalid, wr_pulse}, '0);
    check("reset_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, '0);
    @(posedge ACLK); #1 ARESET = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check("readies_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    @(posedge ACLK); #1;

    for (int i = 0; i < 4; i++) do_read(8'(i * 4), 0);

    do_write(8'h04, 32'h11223344, 4'b0101, 0, 0, 0);
    do_read(8'h04, 0);

    // W leads AW by 3 cycles; B stalled 5 cycles
    do_write(8'h00, 32'hA5A5A5A5, 4'hF, 3, 0, 5);
    do_read(8'h00, 2);

    do_write(8'h0C, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(8'h0C, 0);
    do_read(8'h10, 0);
    do_read(8'h3C, 1);
    do_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, 1, 0);
    do_write(8'h10, 32'h0, 4'hF, 0, 0, 0);

    // Read collides with commit of the same register
    do_write(8'h08, 32'h5, 4'hF, 0, 0, 0);
    exp_r_q.push_back(exp_read(8'h08));
    model_write(8'h08, 32'h9, 4'hF);
    s_axi_awaddr = 8'h08; s_axi_wdata = 32'h9; s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge ACLK);
    check("col_aw_w_ready", {s_axi_awready, s_axi_wready}, 2'b11);
    @(posedge ACLK); #1;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_araddr = 8'h08; s_axi_arvalid = 1'b1;
    @(negedge ACLK);
    check("col_arready", s_axi_arready, 1'b1);
    check("col_commit_pulse", wr_pulse, 4'b0100);
    @(posedge ACLK); #1;
    s_axi_arvalid = 1'b0; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge ACLK);
    check("col_r_b_valid", {s_axi_rvalid, s_axi_bvalid}, 2'b11);
    @(posedge ACLK); #1;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    do_read(8'h08, 0);

    // Reset with an AW captured: it must be discarded
    drive_aw(8'h00, 0);
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(posedge ACLK); #1;
    do_write(8'h08, 32'h00000077, 4'hF, 3, 0, 0);
    do_read(8'h00, 0);
    do_read(8'h08, 0);

    for (int n = 0; n < 60; n++) begin
      ridx = 3'($urandom_range(0, 5));
`ifdef AXIL_REGBANK_IRQ_EN
      if (ridx == 3'd4) ridx = 3'd5;
`endif
      ra = {3'b000, ridx, 2'($urandom)};
      if ($urandom_range(0, 1) == 1)
        do_write(ra, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 3));
      else
        do_read(ra, $urandom_range(0, 3));
    end

`ifdef AXIL_REGBANK_IRQ_EN
    irq_event = 32'h1;
    @(posedge ACLK); #1 irq_event = '0;
    model_irq = 32'h1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("irq_rise", irq, 1'b1);
    @(posedge ACLK); #1;
    irq_event = 32'h1;
    do_write(8'h10, 32'h1, 4'hF, 0, 0, 0);
    irq_event = '0;
    model_irq = model_irq | 32'h1;
    @(negedge ACLK);
    check("irq_set_wins", irq, 1'b1);
    @(posedge ACLK); #1;
    do_read(8'h10, 0);
    do_write(8'h10, 32'h1, 4'hF, 0, 0, 0);
    @(negedge ACLK);
    check("irq_fall", irq, 1'b0);
    @(posedge ACLK); #1;
    do_read(8'h10, 0);
`endif

    repeat (5) @(posedge ACLK);
    check("b_queue_drained", exp_b_q.size(), 0);
    check("r_queue_drained", exp_r_q.size(), 0);
    check("pulse_queue_drained", exp_p_q.size(), 0);
    for (int i = 0; i < 4; i++)
      if (!RO_MASK[i]) check("reg_out", reg_out[i*32 +: 32], model[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
